// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types for the streaming min/max comparator:
//   state_t : frame FSM encoding (IDLE / ACCUM / DONE)
//   gql_t   : one-hot greater / equal / less result of a magnitude compare
// ---------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic g;    // a >  b
        logic q;    // a == b
        logic l;    // a <  b
    } gql_t;

endpackage : cmp_pkg

// File: rtl/cmp_mag_gql.sv
// ---------------------------------------------------------------------------
// cmp_mag_gql
// Combinational G/Q/L magnitude comparator, signed or unsigned.
// Ports:
//   a, b        : WIDTH-bit operands
//   signed_mode : 1 = two's complement, 0 = unsigned
//   res         : one-hot {g, q, l} for a versus b
// ---------------------------------------------------------------------------
module cmp_mag_gql
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output gql_t             res
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so a single unsigned comparator serves both modes.
    always_comb begin
        a_key            = a;
        b_key            = b;
        a_key[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
        b_key[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
        res.g            = (a_key >  b_key);
        res.q            = (a_key == b_key);
        res.l            = (a_key <  b_key);
    end

endmodule : cmp_mag_gql

// File: rtl/cmp_stream_minmax.sv
// ---------------------------------------------------------------------------
// cmp_stream_minmax
// Streaming min/max tracker over a frame of WIDTH-bit samples. Samples come
// in over a valid/ready handshake; the result (min/max values, the index of
// their first occurrence, and a saturating sample count) is held behind a
// res_valid/res_ready handshake until the consumer takes it.
//
// Optional feature macro: CMP_THRESH_EN
//   adds input thresh (latched on the first sample) and output over_cnt
//   (saturating count of samples strictly greater than thresh).
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready        : sample handshake (in_ready is low only in DONE)
//   in_data, in_last         : sample value, end-of-frame marker
//   signed_mode              : compare mode, sampled on the first sample
//   res_valid/res_ready      : result handshake
//   min_val, max_val         : extreme values of the frame
//   min_idx, max_idx         : index of first occurrence of each extreme
//   count, cnt_sat           : accepted samples (saturating), saturation flag
//   thresh, over_cnt         : threshold feature (CMP_THRESH_EN only)
// ---------------------------------------------------------------------------
module cmp_stream_minmax
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             signed_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] count,
    output logic             cnt_sat
`ifdef CMP_THRESH_EN
    ,
    input  logic [WIDTH-1:0] thresh,
    output logic [CNT_W-1:0] over_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic             mode_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic [CNT_W-1:0] min_idx_q;
    logic [CNT_W-1:0] max_idx_q;
    logic [CNT_W-1:0] count_q;
    logic             cnt_sat_q;
    logic [CNT_W-1:0] count_d;

    logic accept;
    gql_t gql_min;
    gql_t gql_max;

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid & in_ready;

    // Saturating increment; the held value doubles as the index for any
    // sample arriving after saturation.
    assign count_d = (count_q == CNT_MAX) ? CNT_MAX : (count_q + CNT_ONE);

    cmp_mag_gql #(.WIDTH(WIDTH)) u_cmp_min (
        .a           (in_data),
        .b           (min_q),
        .signed_mode (mode_q),
        .res         (gql_min)
    );

    cmp_mag_gql #(.WIDTH(WIDTH)) u_cmp_max (
        .a           (in_data),
        .b           (max_q),
        .signed_mode (mode_q),
        .res         (gql_max)
    );

    // Only "strictly less" of the min compare and "strictly greater" of the
    // max compare matter: ties keep the earlier index.
    logic unused_gql;
    assign unused_gql = ^{gql_min.g, gql_min.q, gql_max.l, gql_max.q};

`ifdef CMP_THRESH_EN
    logic [WIDTH-1:0] thresh_q;
    logic [CNT_W-1:0] over_cnt_q;
    logic [WIDTH-1:0] thr_sel;
    logic             thr_mode_sel;
    gql_t             gql_thr;

    // The first sample of a frame is judged against the live thresh and
    // signed_mode inputs, since they are only being latched on that edge.
    assign thr_sel      = (state_q == IDLE) ? thresh      : thresh_q;
    assign thr_mode_sel = (state_q == IDLE) ? signed_mode : mode_q;

    cmp_mag_gql #(.WIDTH(WIDTH)) u_cmp_thr (
        .a           (in_data),
        .b           (thr_sel),
        .signed_mode (thr_mode_sel),
        .res         (gql_thr)
    );

    logic unused_thr;
    assign unused_thr = ^{gql_thr.q, gql_thr.l};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q   <= '0;
            over_cnt_q <= '0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                thresh_q   <= thresh;
                over_cnt_q <= gql_thr.g ? CNT_ONE : '0;
            end else if (gql_thr.g && (over_cnt_q != CNT_MAX)) begin
                over_cnt_q <= over_cnt_q + CNT_ONE;
            end
        end
    end

    assign over_cnt = over_cnt_q;
`endif

    // Frame FSM with all result registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            res_valid_q <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            min_idx_q   <= '0;
            max_idx_q   <= '0;
            count_q     <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        min_q       <= in_data;
                        max_q       <= in_data;
                        min_idx_q   <= '0;
                        max_idx_q   <= '0;
                        count_q     <= CNT_ONE;
                        cnt_sat_q   <= 1'b0;
                        mode_q      <= signed_mode;
                        state_q     <= in_last ? DONE : ACCUM;
                        res_valid_q <= in_last;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (gql_min.l) begin
                            min_q     <= in_data;
                            min_idx_q <= count_q;
                        end
                        if (gql_max.g) begin
                            max_q     <= in_data;
                            max_idx_q <= count_q;
                        end
                        count_q <= count_d;
                        if (count_q == CNT_MAX) begin
                            cnt_sat_q <= 1'b1;
                        end
                        if (in_last) begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign min_val   = min_q;
    assign max_val   = max_q;
    assign min_idx   = min_idx_q;
    assign max_idx   = max_idx_q;
    assign count     = count_q;
    assign cnt_sat   = cnt_sat_q;

endmodule : cmp_stream_minmax

// File: tb/tb_cmp_stream_minmax.sv
// ---------------------------------------------------------------------------
// tb_cmp_stream_minmax
// Self-checking bench: a CNT_W=8 instance for most scenarios and a CNT_W=3
// instance for saturation. Expected results come from a plain scan over the
// frame's samples using integer ordering.
// ---------------------------------------------------------------------------
module tb_cmp_stream_minmax;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_valid3 = 1'b0;
    logic       in_last = 1'b0;
    logic       signed_mode = 1'b0;
    logic       res_ready = 1'b0;
    logic       res_ready3 = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready, res_valid, cnt_sat;
    logic [7:0] min_val, max_val, min_idx, max_idx, count;
    logic       in_ready3, res_valid3, cnt_sat3;
    logic [7:0] min_val3, max_val3;
    logic [2:0] min_idx3, max_idx3, count3;

`ifdef CMP_THRESH_EN
    logic [7:0] thresh = 8'h00;
    logic [7:0] over_cnt;
    logic [2:0] over_cnt3;
`endif

    always #5 clk = ~clk;

    cmp_stream_minmax #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .signed_mode(signed_mode),
        .res_valid(res_valid), .res_ready(res_ready),
        .min_val(min_val), .max_val(max_val), .min_idx(min_idx),
        .max_idx(max_idx), .count(count), .cnt_sat(cnt_sat)
`ifdef CMP_THRESH_EN
        , .thresh(thresh), .over_cnt(over_cnt)
`endif
    );

    cmp_stream_minmax #(.WIDTH(8), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data), .in_last(in_last), .signed_mode(signed_mode),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .min_val(min_val3), .max_val(max_val3), .min_idx(min_idx3),
        .max_idx(max_idx3), .count(count3), .cnt_sat(cnt_sat3)
`ifdef CMP_THRESH_EN
        , .thresh(thresh), .over_cnt(over_cnt3)
`endif
    );

    int vecs = 0;
    int errs = 0;

    // Frame under test and its expected results
    logic [7:0] smp[$];
    bit         e_mode;
    logic [7:0] thr;
    logic [7:0] e_min, e_max;
    int         e_mini, e_maxi, e_cnt, e_over;
    bit         e_sat;
    bit         rv_before_last;

    function automatic int key(input logic [7:0] x);
        return e_mode ? int'($signed(x)) : int'(x);
    endfunction

    // Reference: linear scan, indices/counts clipped to 2^cw-1.
    function automatic void model(input int cw);
        int mx = (1 << cw) - 1;
        e_min  = smp[0];
        e_max  = smp[0];
        e_mini = 0;
        e_maxi = 0;
        e_over = 0;
        for (int i = 0; i < smp.size(); i++) begin
            if (key(smp[i]) < key(e_min)) begin
                e_min  = smp[i];
                e_mini = (i > mx) ? mx : i;
            end
            if (key(smp[i]) > key(e_max)) begin
                e_max  = smp[i];
                e_maxi = (i > mx) ? mx : i;
            end
            if (key(smp[i]) > key(thr) && e_over < mx) e_over++;
        end
        e_cnt = (smp.size() > mx) ? mx : smp.size();
        e_sat = (smp.size() > mx);
    endfunction

    // Drives the queued samples from a negedge; returns on the negedge after
    // the final accept. signed_mode/thresh wander after the first sample.
    task automatic send_frame(input bit use3, input bit no_last);
        int g;
        for (int i = 0; i < smp.size(); i++) begin
            in_data     = smp[i];
            in_last     = (i == smp.size() - 1) && !no_last;
            signed_mode = (i == 0) ? e_mode : ((i % 2) == 1 ? ~e_mode : 1'($urandom));
`ifdef CMP_THRESH_EN
            thresh      = (i == 0) ? thr : 8'($urandom);
`endif
            if (use3) in_valid3 = 1'b1; else in_valid = 1'b1;
            g = 0;
            while (!(use3 ? in_ready3 : in_ready) && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                vecs++;
                errs++;
                $display("FAIL send_timeout got=in_ready_low exp=in_ready_high");
            end
            if (i == smp.size() - 1) rv_before_last = use3 ? res_valid3 : res_valid;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic take_result(input bit use3);
        if (use3) res_ready3 = 1'b1; else res_ready = 1'b1;
        @(negedge clk);
        res_ready  = 1'b0;
        res_ready3 = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        vecs++;
        if ({res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat, in_ready} !== {1'b0, 40'd0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL reset_state got=%h exp=%h",
                     {res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat, in_ready}, {1'b0, 40'd0, 1'b0, 1'b1});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed_frame();
        smp = '{8'h05, 8'hFD, 8'h7F, 8'h80, 8'h7F};
        e_mode = 1'b1; thr = 8'h00;
        model(8);
        send_frame(1'b0, 1'b0);
        vecs++;
        if ({rv_before_last, res_valid} !== 2'b01) begin
            errs++;
            $display("FAIL signed_latency got=%b exp=01", {rv_before_last, res_valid});
        end
        vecs++;
        if ({min_val, max_val, min_idx, max_idx, count, cnt_sat} !== {e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt), e_sat}) begin
            errs++;
            $display("FAIL signed_frame got=%h exp=%h", {min_val, max_val, min_idx, max_idx, count, cnt_sat},
                     {e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt), e_sat});
        end
        take_result(1'b0);
    endtask

    task automatic test_unsigned_frame();
        smp = '{8'h05, 8'hFD, 8'h7F, 8'h80, 8'h7F};
        e_mode = 1'b0; thr = 8'h00;
        model(8);
        send_frame(1'b0, 1'b0);
        vecs++;
        if ({res_valid, min_val, max_val, min_idx, max_idx, count} !== {1'b1, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt)}) begin
            errs++;
            $display("FAIL unsigned_frame got=%h exp=%h", {res_valid, min_val, max_val, min_idx, max_idx, count},
                     {1'b1, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt)});
        end
        take_result(1'b0);
        vecs++;
        if ({res_valid, in_ready} !== 2'b01) begin
            errs++;
            $display("FAIL release_to_idle got=%b exp=01", {res_valid, in_ready});
        end
    endtask

    task automatic test_single_hold();
        smp = '{8'h42};
        e_mode = 1'($urandom); thr = 8'h10;
        model(8);
        send_frame(1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            vecs++;
            if ({in_ready, res_valid, min_val, max_val, min_idx, max_idx, count} !== {2'b01, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt)}) begin
                errs++;
                $display("FAIL hold_cycle%0d got=%h exp=%h", c, {in_ready, res_valid, min_val, max_val, min_idx, max_idx, count},
                         {2'b01, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt)});
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result(1'b0);
        vecs++;
        if ({in_ready, res_valid, min_val} !== {2'b10, 8'h42}) begin
            errs++;
            $display("FAIL hold_release got=%h exp=%h", {in_ready, res_valid, min_val}, {2'b10, 8'h42});
        end
    endtask

    task automatic test_saturation();
        smp = {};
        for (int i = 0; i < 9; i++) smp.push_back(8'($urandom_range(0, 15)));
        smp.push_back(8'h10);
        e_mode = 1'($urandom); thr = 8'h08;
        model(3);
        send_frame(1'b1, 1'b0);
        vecs++;
        if ({res_valid3, min_val3, max_val3, min_idx3, max_idx3, count3, cnt_sat3} !==
            {1'b1, e_min, e_max, 3'(e_mini), 3'(e_maxi), 3'(e_cnt), e_sat}) begin
            errs++;
            $display("FAIL saturation got=%h exp=%h", {res_valid3, min_val3, max_val3, min_idx3, max_idx3, count3, cnt_sat3},
                     {1'b1, e_min, e_max, 3'(e_mini), 3'(e_maxi), 3'(e_cnt), e_sat});
        end
`ifdef CMP_THRESH_EN
        vecs++;
        if (over_cnt3 !== 3'(e_over)) begin
            errs++;
            $display("FAIL sat_over_cnt got=%0d exp=%0d", over_cnt3, e_over);
        end
`endif
        take_result(1'b1);
    endtask

    task automatic test_reset_midframe();
        smp = '{8'h90, 8'h11};
        e_mode = 1'b0; thr = 8'h00;
        send_frame(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat} !== 42'd0) begin
            errs++;
            $display("FAIL midframe_reset got=%h exp=0", {res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        smp = '{8'h01, 8'h02};
        e_mode = 1'b1;
        model(8);
        send_frame(1'b0, 1'b0);
        vecs++;
        if ({res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat} !== {1'b1, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt), e_sat}) begin
            errs++;
            $display("FAIL after_reset_frame got=%h exp=%h", {res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat},
                     {1'b1, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt), e_sat});
        end
        take_result(1'b0);
    endtask

`ifdef CMP_THRESH_EN
    task automatic test_thresh();
        smp = '{8'h01, 8'hFF, 8'h00, 8'h7F};
        e_mode = 1'b1; thr = 8'h00;
        model(8);
        send_frame(1'b0, 1'b0);
        vecs++;
        if (over_cnt !== 8'(e_over)) begin
            errs++;
            $display("FAIL thresh_over_cnt got=%0d exp=%0d", over_cnt, e_over);
        end
        take_result(1'b0);
    endtask
`endif

    task automatic test_random_frames();
        int n, w;
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, 12);
            smp = {};
            for (int i = 0; i < n; i++) smp.push_back(8'($urandom));
            e_mode = 1'($urandom);
            thr    = 8'($urandom);
            model(8);
            send_frame(1'b0, 1'b0);
            w = $urandom_range(0, 3);
            for (int c = 0; c < w; c++) @(negedge clk);
            vecs++;
            if ({res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat} !== {1'b1, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt), e_sat}) begin
                errs++;
                $display("FAIL random_frame%0d got=%h exp=%h", f, {res_valid, min_val, max_val, min_idx, max_idx, count, cnt_sat},
                         {1'b1, e_min, e_max, 8'(e_mini), 8'(e_maxi), 8'(e_cnt), e_sat});
            end
`ifdef CMP_THRESH_EN
            vecs++;
            if (over_cnt !== 8'(e_over)) begin
                errs++;
                $display("FAIL random_over_cnt%0d got=%0d exp=%0d", f, over_cnt, e_over);
            end
`endif
            take_result(1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_signed_frame();
        test_unsigned_frame();
        test_single_hold();
        test_saturation();
        test_reset_midframe();
`ifdef CMP_THRESH_EN
        test_thresh();
`endif
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_cmp_stream_minmax

// File: doc/cmp_stream_minmax.md
Name: cmp_stream_minmax

Overview:
- Parametrised streaming successor to the fixed 8-bit signed G/Q/L comparator.
- Accepts a frame of WIDTH-bit samples over a valid/ready handshake and compares each sample against a running minimum and maximum.
- Supports signed (two's complement) or unsigned mode, selected per frame.
- Returns min/max values, their indices and the sample count through a held result handshake; feeds downstream ALU status logic.

Parameters:
- WIDTH, 8, sample width in bits (>=2).
- CNT_W, 8, width of count and index fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  sample value.
- in_last  input  1  marks final sample of frame; qualified by in_valid&in_ready.
- signed_mode  input  1  1=two's complement compare, 0=unsigned; sampled on first sample of frame.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- min_val  output  WIDTH  smallest sample in frame.
- max_val  output  WIDTH  largest sample in frame.
- min_idx  output  CNT_W  index of first occurrence of min_val.
- max_idx  output  CNT_W  index of first occurrence of max_val.
- count  output  CNT_W  samples accepted (saturating).
- cnt_sat  output  1  count saturated during frame.

Behaviour:
- Async reset: state=IDLE; min_val, max_val, min_idx, max_idx, count, cnt_sat, res_valid all 0. Reset mid-frame discards the frame with no result.
- Accept = in_valid & in_ready. in_ready = (state != DONE), combinational from state only; no dependence on in_valid.
- States:
  - IDLE: accept loads min=max=in_data, min_idx=max_idx=0, count=1, cnt_sat=0, and latches mode_q=signed_mode. Next state is DONE if in_last, else ACCUM. Stale results stay visible in IDLE.
  - ACCUM: on each accept, compare in_data against min/max using mode_q.
    - Strictly less: min_val=in_data, min_idx=count.
    - Strictly greater: max_val=in_data, max_idx=count.
    - Ties keep the earlier index.
    - count increments; at 2^CNT_W-1 it holds and sets cnt_sat. Index captured after saturation is 2^CNT_W-1.
    - Accept with in_last goes to DONE.
  - DONE: res_valid=1, in_ready=0, all result outputs stable. res_valid&res_ready returns to IDLE next cycle.
- Latency: res_valid rises the cycle after the last sample is accepted. One frame is in flight; at most one frame per 2 cycles, plus one cycle per sample.
- Comparison: signed compare inverts the MSB of both operands, then does an unsigned magnitude compare. Unsigned compare is a plain magnitude compare. Both are computed combinationally within the accept cycle.
- signed_mode changes mid-frame are ignored.
- in_data and in_last are don't-care while in_valid=0.

Optional Feature:
- Macro: CMP_THRESH_EN.
- Defined:
  - Adds input thresh (WIDTH) and output over_cnt (CNT_W).
  - thresh is latched on the first sample of the frame.
  - over_cnt counts samples strictly greater than thresh under mode_q, saturating; it is reset to 0 and held in DONE.
- Undefined: both ports are absent and the logic is removed; all other behaviour is identical.

Decomposition:
- Shared package (cmp_pkg): state encoding constants (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and a G/Q/L result struct/type.
- One sub-module, cmp_mag_gql: combinational, parametrised by WIDTH, inputs a, b, signed_mode, outputs G/Q/L. Instantiated twice (vs min, vs max) and a third time under CMP_THRESH_EN.

Test Plan:
- Signed frame, WIDTH=8, samples 0x05, 0xFD, 0x7F, 0x80, 0x7F (last):
  - min_val=0x80, min_idx=3, max_val=0x7F, max_idx=2, count=5.
  - res_valid exactly 1 cycle after the last accept.
- Same samples with signed_mode=0:
  - min_val=0x05 idx0, max_val=0xFD idx1.
  - Toggling signed_mode mid-frame has no effect.
- Single-sample frame 0x42 with in_last:
  - min=max=0x42, indices 0, count=1.
  - Hold res_ready=0 for 3 cycles: in_ready=0, outputs stable, in_valid pulses ignored. Release: IDLE, in_ready=1.
- CNT_W=3, 10 samples, 0x10 at position 9: count=7, cnt_sat=1, max_idx=7.
- rst_n low for 1 cycle after 2 samples of a frame: all outputs 0 immediately. Next frame 0x01, 0x02 (last) gives count=2, no residue from the aborted frame.
- With CMP_THRESH_EN, thresh=0x00, signed mode, samples 0x01, 0xFF, 0x00, 0x7F (last): over_cnt=2.
